// File: rtl/instr_fetcher_pkg.sv
// ============================================================================
// Module : instr_fetcher_pkg
// Brief  : Shared widths, constants and FSM encoding for the instruction fetcher.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_fetcher_pkg;

    localparam int PcLength    = 32;
    localparam int InstrLength = 32;

    localparam logic [InstrLength-1:0] Zero = '0;
    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    // Refill reads four bytes (cnt 0..3) and commits the line on the fifth cycle
    localparam logic [2:0] FillLastCnt = 3'd4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/icache_array.sv
// ============================================================================
// Module : icache_array
// Brief  : Direct-mapped one-word-per-line storage; combinational read port,
//          synchronous write port. Only the valid bits are reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module icache_array #(
    parameter int INDEX_WIDTH = 8,
    parameter int TAG_WIDTH   = 22,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] i_rd_idx,
    output logic                   o_rd_valid,
    output logic [TAG_WIDTH-1:0]   o_rd_tag,
    output logic [DATA_WIDTH-1:0]  o_rd_data,
    input  logic                   i_wr_en,
    input  logic [INDEX_WIDTH-1:0] i_wr_idx,
    input  logic [TAG_WIDTH-1:0]   i_wr_tag,
    input  logic [DATA_WIDTH-1:0]  i_wr_data
);

    localparam int DEPTH = 1 << INDEX_WIDTH;

    logic [DEPTH-1:0]      r_valid;
    logic [TAG_WIDTH-1:0]  r_tag  [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule

`default_nettype wire

// File: rtl/instr_fetcher.sv
// ============================================================================
// Module : instr_fetcher
// Brief  : Instruction-queue fetch responder with a direct-mapped word cache,
//          refilled bytewise from RAM on a miss. Optional FETCH_PERF_EN adds
//          hit/miss counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetcher
    import instr_fetcher_pkg::*;
#(
    parameter int INDEX_WIDTH = 8,
    parameter int PC_WIDTH    = PcLength
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   is_exception_from_rob,
    input  logic [PC_WIDTH-1:0]    pc_from_iq,
    input  logic                   is_empty_from_iq,
    output logic                   is_stall_to_iq,
    output logic                   is_finish_to_iq,
    output logic                   is_instr_to_iq,
    output logic [InstrLength-1:0] instr_to_iq,
    input  logic [7:0]             mem_din,
    output logic [PC_WIDTH-1:0]    mem_a,
    output logic                   mem_wr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            hit_cnt_out,
    output logic [31:0]            miss_cnt_out
`endif
);

    localparam int TAG_WIDTH = PC_WIDTH - INDEX_WIDTH - 2;

    fetch_state_t            r_state;
    fetch_state_t            w_state_nxt;
    logic [2:0]              r_cnt;
    logic [2:0]              w_cnt_nxt;
    logic [PC_WIDTH-1:0]     r_pc_q;
    logic [7:0]              r_byte [0:2];

    logic                    w_req;
    logic                    w_hit;
    logic                    w_rsp;
    logic                    w_miss_start;
    logic                    w_fill_wr;
    logic                    w_rd_valid;
    logic [TAG_WIDTH-1:0]    w_rd_tag;
    logic [InstrLength-1:0]  w_rd_data;
    logic [InstrLength-1:0]  w_fill_word;
    logic                    w_unused;

    assign w_req       = !is_empty_from_iq && !is_exception_from_rob;
    assign w_hit       = w_rd_valid && (w_rd_tag == pc_from_iq[PC_WIDTH-1:INDEX_WIDTH+2]);
    assign w_fill_word = {mem_din, r_byte[2], r_byte[1], r_byte[0]};
    assign w_unused    = ^pc_from_iq[1:0];

    assign is_stall_to_iq = (r_state != IDLE) || (w_req && !w_hit);
    assign mem_wr         = False;

    icache_array #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH),
        .DATA_WIDTH  (InstrLength)
    ) u_icache_array (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (pc_from_iq[INDEX_WIDTH+1:2]),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_fill_wr),
        .i_wr_idx   (r_pc_q[INDEX_WIDTH+1:2]),
        .i_wr_tag   (r_pc_q[PC_WIDTH-1:INDEX_WIDTH+2]),
        .i_wr_data  (w_fill_word)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_rsp        = False;
        w_miss_start = False;
        w_fill_wr    = False;
        mem_a        = '0;
        case (r_state)
            IDLE: begin
                if (w_req && w_hit) begin
                    w_rsp = True;
                end else if (w_req) begin
                    w_miss_start = True;
                    w_state_nxt  = FILL;
                    w_cnt_nxt    = '0;
                end
            end
            FILL: begin
                if (r_cnt == FillLastCnt) begin
                    w_fill_wr   = True;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    mem_a     = r_pc_q + PC_WIDTH'(r_cnt);
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        // A flush discards any partial line; completed lines stay valid
        if (is_exception_from_rob) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_fill_wr   = False;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_pc_q          <= '0;
            r_byte[0]       <= '0;
            r_byte[1]       <= '0;
            r_byte[2]       <= '0;
            is_finish_to_iq <= False;
            is_instr_to_iq  <= False;
            instr_to_iq     <= Zero;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            is_finish_to_iq <= w_rsp;
            is_instr_to_iq  <= w_rsp;
            if (w_rsp) begin
                instr_to_iq <= w_rd_data;
            end
            if (w_miss_start) begin
                r_pc_q <= pc_from_iq;
            end
            // Byte for the address driven at cnt-1 lands while cnt is current
            if (r_state == FILL && r_cnt != 3'd0 && r_cnt != FillLastCnt) begin
                r_byte[2'(r_cnt - 3'd1)] <= mem_din;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_out  <= '0;
            miss_cnt_out <= '0;
        end else begin
            if (w_rsp) begin
                hit_cnt_out <= hit_cnt_out + 32'd1;
            end
            if (w_miss_start) begin
                miss_cnt_out <= miss_cnt_out + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetcher.sv
// ============================================================================
// Module : tb_instr_fetcher
// Brief  : Cycle-table self-checking bench for instr_fetcher with a byte RAM model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fetcher;

    typedef struct {
        logic [31:0] pc;
        logic        empty;
        logic        exc;
        logic        stall;
        logic        fin;
        logic [31:0] instr;
        logic [31:0] mema;
    } vec_t;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        exc   = 1'b0;
    logic        empty = 1'b1;
    logic [31:0] pc    = 32'h0;
    logic [7:0]  mem_din = 8'h0;
    logic        stall;
    logic        fin;
    logic        is_instr;
    logic [31:0] instr;
    logic [31:0] mem_a;
    logic        mem_wr;
`ifdef FETCH_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vq[$];

    instr_fetcher dut (
        .clk                   (clk),
        .rst                   (rst),
        .is_exception_from_rob (exc),
        .pc_from_iq            (pc),
        .is_empty_from_iq      (empty),
        .is_stall_to_iq        (stall),
        .is_finish_to_iq       (fin),
        .is_instr_to_iq        (is_instr),
        .instr_to_iq           (instr),
        .mem_din               (mem_din),
        .mem_a                 (mem_a),
        .mem_wr                (mem_wr)
`ifdef FETCH_PERF_EN
        ,
        .hit_cnt_out           (hit_cnt),
        .miss_cnt_out          (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'h1000: return 8'h13;
            32'h1001: return 8'h05;
            32'h1002: return 8'h00;
            32'h1003: return 8'h00;
            default:  return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {ram_byte(a + 32'd3), ram_byte(a + 32'd2), ram_byte(a + 32'd1), ram_byte(a)};
    endfunction

    // RAM answers one cycle after the address
    always @(posedge clk) mem_din <= ram_byte(mem_a);

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] p, input logic e, input logic x, input logic st,
                       input logic fi, input logic [31:0] ins, input logic [31:0] ma);
        vq.push_back('{pc: p, empty: e, exc: x, stall: st, fin: fi, instr: ins, mema: ma});
    endtask

    // Miss detect cycle, four byte-address cycles, commit cycle
    task automatic add_miss(input logic [31:0] p, input logic fi, input logic [31:0] ins);
        add(p, N, N, Y, fi, ins, 32'h0);
        for (int k = 0; k < 4; k++) add(p, N, N, Y, N, 32'h0, p + 32'(k));
        add(p, N, N, Y, N, 32'h0, 32'h0);
    endtask

    initial begin
        // First miss and retry hit
        add_miss(32'h1000, N, 32'h0);
        add(32'h1000, N, N, N, N, 32'h0, 32'h0);
        // Second line, then back-to-back hits
        add_miss(32'h1004, Y, 32'h0000_0513);
        add(32'h1004, N, N, N, N, 32'h0, 32'h0);
        add(32'h1000, N, N, N, Y, word_at(32'h1004), 32'h0);
        add(32'h1004, N, N, N, Y, 32'h0000_0513, 32'h0);
        add(32'h0, Y, N, N, Y, word_at(32'h1004), 32'h0);
        add(32'h0, Y, N, N, N, 32'h0, 32'h0);
        // Same index, different tag evicts, then the old PC misses again
        add_miss(32'h1400, N, 32'h0);
        add(32'h1400, N, N, N, N, 32'h0, 32'h0);
        add_miss(32'h1000, Y, word_at(32'h1400));
        add(32'h1000, N, N, N, N, 32'h0, 32'h0);
        add(32'h0, Y, N, N, Y, 32'h0000_0513, 32'h0);
        // Flush at cnt=2 discards the partial line
        add(32'h2010, N, N, Y, N, 32'h0, 32'h0);
        add(32'h2010, N, N, Y, N, 32'h0, 32'h2010);
        add(32'h2010, N, N, Y, N, 32'h0, 32'h2011);
        add(32'h2010, N, Y, Y, N, 32'h0, 32'h2012);
        add(32'h2010, Y, N, N, N, 32'h0, 32'h0);
        add_miss(32'h2010, N, 32'h0);
        add(32'h2010, N, N, N, N, 32'h0, 32'h0);
        add(32'h0, Y, N, N, Y, word_at(32'h2010), 32'h0);
        // Flush alongside a request that would hit: ignored
        add(32'h1000, N, Y, N, N, 32'h0, 32'h0);
        add(32'h0, Y, N, N, N, 32'h0, 32'h0);

        repeat (2) @(negedge clk);
        #1;
        chk1("rst stall", stall, N);
        chk1("rst finish", fin, N);
        chk1("rst is_instr", is_instr, N);
        chk32("rst instr", instr, 32'h0);
        chk32("rst mem_a", mem_a, 32'h0);
        chk1("rst mem_wr", mem_wr, N);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) begin
            @(negedge clk);
            pc    = vq[i].pc;
            empty = vq[i].empty;
            exc   = vq[i].exc;
            #1;
            chk1($sformatf("v%0d stall", i), stall, vq[i].stall);
            chk1($sformatf("v%0d finish", i), fin, vq[i].fin);
            chk1($sformatf("v%0d is_instr", i), is_instr, vq[i].fin);
            chk32($sformatf("v%0d mem_a", i), mem_a, vq[i].mema);
            chk1($sformatf("v%0d mem_wr", i), mem_wr, N);
            if (vq[i].fin) chk32($sformatf("v%0d instr", i), instr, vq[i].instr);
        end
        exc = 1'b0;

`ifdef FETCH_PERF_EN
        chk32("perf hits", hit_cnt, 32'd7);
        chk32("perf misses", miss_cnt, 32'd6);
`endif

        // Idle queue
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            empty = 1'b1;
            #1;
            chk1($sformatf("idle%0d stall", k), stall, N);
            chk1($sformatf("idle%0d finish", k), fin, N);
            chk32($sformatf("idle%0d mem_a", k), mem_a, 32'h0);
        end

        // Reset in the middle of a refill clears the valid bits
        @(negedge clk);
        pc = 32'h3000;
        empty = 1'b0;
        #1;
        chk1("rstfill miss stall", stall, Y);
        @(negedge clk);
        #1;
        chk32("rstfill mem_a0", mem_a, 32'h3000);
        @(negedge clk);
        #1;
        chk32("rstfill mem_a1", mem_a, 32'h3001);
        #2;
        empty = 1'b1;
        rst = 1'b1;
        #1;
        chk1("rstfill stall", stall, N);
        chk32("rstfill mem_a", mem_a, 32'h0);
        chk1("rstfill finish", fin, N);
`ifdef FETCH_PERF_EN
        chk32("rstfill hits", hit_cnt, 32'd0);
        chk32("rstfill misses", miss_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        pc = 32'h1000;
        empty = 1'b0;
        #1;
        chk1("post-rst 1000 misses", stall, Y);
        @(negedge clk);
        #1;
        chk32("post-rst mem_a", mem_a, 32'h1000);
        repeat (5) @(negedge clk);
        #1;
        chk1("post-rst retry stall", stall, N);
        @(negedge clk);
        empty = 1'b1;
        #1;
        chk1("post-rst finish", fin, Y);
        chk32("post-rst instr", instr, 32'h0000_0513);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_fetcher.md
Name: instr_fetcher

Overview:
Fetch-side responder for the instruction queue's PC-request / instruction-return handshake. It accepts one PC per cycle from the queue, looks it up in a direct-mapped word instruction cache, and returns the instruction one cycle later on a hit. On a miss it stalls the queue and refills the word from byte-wide RAM. It sits between the instruction queue and the memory port and is flushed by the ROB on exception.

Parameters:
INDEX_WIDTH, 8, cache index bits; the cache has 2^INDEX_WIDTH one-word lines.
PC_WIDTH, 32, PC and address width.

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
is_exception_from_rob  input  1  flush: abort any refill; the request in this cycle is ignored
pc_from_iq  input  PC_WIDTH  requested PC; word aligned
is_empty_from_iq  input  1  1 = no request this cycle
is_stall_to_iq  output  1  combinational; 1 = request not accepted, queue must hold its PC
is_finish_to_iq  output  1  registered; 1-cycle pulse, response valid
is_instr_to_iq  output  1  registered; equals is_finish_to_iq (instruction-class response)
instr_to_iq  output  32  registered instruction word
mem_din  input  8  RAM read data; the byte for the address driven in cycle t arrives in cycle t+1
mem_a  output  PC_WIDTH  RAM byte address
mem_wr  output  1  always 0 (read-only port)

Behaviour:
- Reset (async): state=IDLE, cnt=0, all valid bits=0, is_finish_to_iq=0, is_instr_to_iq=0, instr_to_iq=0, mem_a=0. Tag/data arrays are not reset.
- Line fields: idx=pc[INDEX_WIDTH+1:2]; tag=pc[PC_WIDTH-1:INDEX_WIDTH+2]. Lookup is combinational on pc_from_iq.
- req = !is_empty_from_iq && !is_exception_from_rob; hit = valid[idx] && tag match.
- is_stall_to_iq = (state!=IDLE) || (req && !hit).
- IDLE:
  - req && hit: at the edge, instr_to_iq <= data[idx] and finish/instr <= 1 for exactly one cycle. Back-to-back hits give one response per cycle.
  - req && !hit: pc_q <= pc_from_iq, cnt <= 0, go to FILL. No response.
  - Otherwise finish/instr <= 0.
- FILL (5 cycles, cnt 0..4):
  - mem_a = pc_q + cnt for cnt 0..3, and 0 for cnt=4.
  - For cnt>=1, byte[cnt-1] <= mem_din.
  - At the cnt=4 edge: byte3 <= mem_din; write data[idx] = {byte3,byte2,byte1,byte0} (little-endian); write tag; set valid=1; go to IDLE.
  - The fill never drives a response.
- Retry rule: the queue holds its PC while stalled. After the fill, the same PC hits in IDLE and is returned then, so each PC produces exactly one response.
  - Miss timing: detect at T0, FILL T1–T5, hit accepted T6, is_finish_to_iq high T7.
- Exception: in any state, return to IDLE with cnt=0, finish/instr=0, no cache write. A partial line is discarded and completed lines are kept. The queue supplies the new PC from the next cycle.
- Address arithmetic wraps modulo 2^PC_WIDTH.
- Reset mid-FILL: same result as the reset state; valid bits are cleared.

Optional Feature:
FETCH_PERF_EN. When defined, add outputs hit_cnt_out[31:0] and miss_cnt_out[31:0].
- hit_cnt_out increments on each accepted hit; miss_cnt_out increments on each IDLE→FILL transition.
- Both wrap, clear on rst, and are not affected by exception.

When FETCH_PERF_EN is undefined, these ports and counters do not exist and the remaining behaviour is identical.

Decomposition:
- Shared parameters include: PcLength, InstrLength, Zero, True/False, and the FSM state encodings IDLE/FILL.
- One natural sub-module, icache_array: valid/tag/data storage with a combinational read port and a synchronous write port.

Test Plan:
- Reset, then pc_from_iq=0x1000 with empty=0 → stall=1 at T0; mem_a=0x1000..0x1003 in T1–T4. RAM bytes 0x13,0x05,0x00,0x00 → hit at T6, instr_to_iq=0x00000513 with finish=instr=1 at T7.
- Sequential PCs 0x1000 and 0x1004 both cached → two consecutive finish pulses with the correct words and stall=0 throughout.
- Same index, different tag (0x1000, then 0x1400 with INDEX_WIDTH=8) → second request misses and refills; a re-request of 0x1000 then misses again.
- Exception asserted at cnt=2 of a fill → state IDLE next cycle, no finish pulse, line stays invalid; a later request to the same PC misses and refills.
- empty=1 for 10 cycles → stall=0, finish=0, mem_a=0.
- FETCH_PERF_EN defined, one miss then 3 hits → miss_cnt_out=1, hit_cnt_out=4 (including the retry hit).
